// File: rtl/y86_pkg.sv
// -----------------------------------------------------------------------------
// y86_pkg
// Shared definitions for the sequential Y86-64 core: instruction codes,
// special register IDs and default datapath sizes. Fetch and decode/write-back
// both import this package so the encodings live in exactly one place.
// -----------------------------------------------------------------------------
package y86_pkg;

  localparam int DATA_W = 64;  // architectural register width
  localparam int NREG   = 15;  // registers 0..14; ID 0xF has no storage
  localparam int ID_W   = 4;   // width of a register specifier

  // Instruction codes. Kept as plain constants rather than an enum because
  // fetch can deliver undefined codes (C..F) that must flow through untouched.
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Special register IDs.
  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/regfile_2r2w.sv
// -----------------------------------------------------------------------------
// regfile_2r2w
// Program register file with two combinational read ports (A, B) and two
// write ports (E, M). When both write ports target the same register in the
// same cycle, port M wins. Any address without storage (>= NREG, i.e. 0xF)
// reads as 0 and is never written. Reads return pre-edge contents: no bypass.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low clear of every register
//   i_we_e     write enable, port E
//   i_addr_e   write address, port E
//   i_data_e   write data, port E
//   i_we_m     write enable, port M (priority over E)
//   i_addr_m   write address, port M
//   i_data_m   write data, port M
//   i_raddr_a  read address, port A
//   o_rdata_a  read data, port A
//   i_raddr_b  read address, port B
//   o_rdata_b  read data, port B
// -----------------------------------------------------------------------------
module regfile_2r2w #(
  parameter int DATA_W = 64,
  parameter int NREG   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we_e,
  input  logic [3:0]        i_addr_e,
  input  logic [DATA_W-1:0] i_data_e,
  input  logic              i_we_m,
  input  logic [3:0]        i_addr_m,
  input  logic [DATA_W-1:0] i_data_m,
  input  logic [3:0]        i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [3:0]        i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_regs [NREG];

  // NOTE: this storage is a flop array, not a RAM macro, so it can and must be
  // cleared by the asynchronous reset; state is updated with <= so every
  // register samples the same pre-edge inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        // Port M is tested first so it overrides port E on an address clash.
        if (i_we_m && (i_addr_m == 4'(i)))      r_regs[i] <= i_data_m;
        else if (i_we_e && (i_addr_e == 4'(i))) r_regs[i] <= i_data_e;
      end
    end
  end

  // Read muxes scan the populated IDs only, so an unmatched ID reads as 0.
  always_comb begin
    o_rdata_a = '0;
    o_rdata_b = '0;
    for (int i = 0; i < NREG; i++) begin
      if (i_raddr_a == 4'(i)) o_rdata_a = r_regs[i];
      if (i_raddr_b == 4'(i)) o_rdata_b = r_regs[i];
    end
  end

endmodule

// File: rtl/decode_writeback.sv
// -----------------------------------------------------------------------------
// decode_writeback
// Decode and write-back stage of the sequential Y86-64 core. Selects the read
// IDs (srcA/srcB) and write IDs (dstE/dstM) from the fetched icode/rA/rB and
// the execute condition, reads valA/valB combinationally and commits valE and
// valM into the register file on the edge that ends the instruction.
//
// Ports
//   clk, rst_n  clock and asynchronous active-low reset
//   icode       instruction code from fetch
//   rA, rB      register specifiers from fetch (0xF when absent)
//   cnd         condition from execute (cmovXX only)
//   valE        ALU result, written through dstE
//   valM        load data, written through dstM
//   commit      instruction valid with status AOK; gates both writes
//   valA, valB  register[srcA], register[srcB] (0 for ID 0xF)
//   srcA, srcB  decoded read IDs
//   dstE, dstM  decoded write IDs
// -----------------------------------------------------------------------------
module decode_writeback #(
  parameter int DATA_W = y86_pkg::DATA_W,
  parameter int NREG   = y86_pkg::NREG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              cnd,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic              commit,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic [3:0]        srcA,
  output logic [3:0]        srcB,
  output logic [3:0]        dstE,
  output logic [3:0]        dstM
);

  import y86_pkg::*;

  logic [3:0] w_src_a;
  logic [3:0] w_src_b;
  logic [3:0] w_dst_e;
  logic [3:0] w_dst_m;
  logic       w_we_e;
  logic       w_we_m;

  // NOTE: every output of this block gets a default first, so opcodes that
  // do not touch a field (and undefined opcodes) fall to RNONE with no latch.
  always_comb begin
    w_src_a = RNONE;
    w_src_b = RNONE;
    w_dst_e = RNONE;
    w_dst_m = RNONE;
    case (icode)
      I_CMOVXX: begin
        w_src_a = rA;
        // A failed condition turns the move into a no-op.
        w_dst_e = cnd ? rB : RNONE;
      end
      I_IRMOVQ: w_dst_e = rB;
      I_RMMOVQ: begin
        w_src_a = rA;
        w_src_b = rB;
      end
      I_MRMOVQ: begin
        w_src_b = rB;
        w_dst_m = rA;
      end
      I_OPQ: begin
        w_src_a = rA;
        w_src_b = rB;
        w_dst_e = rB;
      end
      I_CALL: begin
        w_src_b = RSP;
        w_dst_e = RSP;
      end
      I_RET: begin
        w_src_a = RSP;
        w_src_b = RSP;
        w_dst_e = RSP;
      end
      I_PUSHQ: begin
        w_src_a = rA;
        w_src_b = RSP;
        w_dst_e = RSP;
      end
      I_POPQ: begin
        w_src_a = RSP;
        w_src_b = RSP;
        w_dst_e = RSP;
        w_dst_m = rA;
      end
      default: ;
    endcase
  end

  // RNONE never writes; the regfile has no storage for it either, but gating
  // here keeps the enables meaningful if NREG is ever raised.
  assign w_we_e = commit && (w_dst_e != RNONE);
  assign w_we_m = commit && (w_dst_m != RNONE);

  regfile_2r2w #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we_e    (w_we_e),
    .i_addr_e  (w_dst_e),
    .i_data_e  (valE),
    .i_we_m    (w_we_m),
    .i_addr_m  (w_dst_m),
    .i_data_m  (valM),
    .i_raddr_a (w_src_a),
    .o_rdata_a (valA),
    .i_raddr_b (w_src_b),
    .o_rdata_b (valB)
  );

  assign srcA = w_src_a;
  assign srcB = w_src_b;
  assign dstE = w_dst_e;
  assign dstM = w_dst_m;

endmodule

// File: tb/tb_decode_writeback.sv
// -----------------------------------------------------------------------------
// tb_decode_writeback
// Self-checking bench for decode_writeback: directed scenarios followed by
// random instruction streams, compared against a register-array model that
// applies the architectural rules of each instruction.
// -----------------------------------------------------------------------------
module tb_decode_writeback;

  localparam int DW = 64;

  logic          clk;
  logic          rst_n;
  logic [3:0]    icode;
  logic [3:0]    rA;
  logic [3:0]    rB;
  logic          cnd;
  logic [DW-1:0] valE;
  logic [DW-1:0] valM;
  logic          commit;
  logic [DW-1:0] valA;
  logic [DW-1:0] valB;
  logic [3:0]    srcA;
  logic [3:0]    srcB;
  logic [3:0]    dstE;
  logic [3:0]    dstM;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] model [15];

  decode_writeback #(.DATA_W(DW), .NREG(15)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .icode  (icode),
    .rA     (rA),
    .rB     (rB),
    .cnd    (cnd),
    .valE   (valE),
    .valM   (valM),
    .commit (commit),
    .valA   (valA),
    .valB   (valB),
    .srcA   (srcA),
    .srcB   (srcB),
    .dstE   (dstE),
    .dstM   (dstM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural register usage of each instruction, read straight from the
  // instruction set definition.
  function automatic void ref_ids(input logic [3:0] ic, input logic [3:0] ra,
                                  input logic [3:0] rb, input logic c,
                                  output logic [3:0] sa, output logic [3:0] sb,
                                  output logic [3:0] de, output logic [3:0] dm);
    sa = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? ra :
         (ic inside {4'h9, 4'hB})             ? 4'h4 : 4'hF;
    sb = (ic inside {4'h4, 4'h5, 4'h6})       ? rb :
         (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
    de = (ic inside {4'h3, 4'h6})             ? rb :
         (ic == 4'h2)                         ? (c ? rb : 4'hF) :
         (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
    dm = (ic inside {4'h5, 4'hB})             ? ra : 4'hF;
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [3:0] id);
    return (id == 4'hF) ? '0 : model[id];
  endfunction

  task automatic expect_eq(input string tag, input logic [DW-1:0] got,
                           input logic [DW-1:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Compare every output against the model for the inputs currently driven.
  task automatic check_all(input string tag);
    logic [3:0] sa, sb, de, dm;
    ref_ids(icode, rA, rB, cnd, sa, sb, de, dm);
    expect_eq({tag, ".srcA"}, {60'd0, srcA}, {60'd0, sa});
    expect_eq({tag, ".srcB"}, {60'd0, srcB}, {60'd0, sb});
    expect_eq({tag, ".dstE"}, {60'd0, dstE}, {60'd0, de});
    expect_eq({tag, ".dstM"}, {60'd0, dstM}, {60'd0, dm});
    expect_eq({tag, ".valA"}, valA, model_read(sa));
    expect_eq({tag, ".valB"}, valB, model_read(sb));
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] ra,
                       input logic [3:0] rb, input logic c,
                       input logic [DW-1:0] e, input logic [DW-1:0] m,
                       input logic cm);
    icode = ic; rA = ra; rB = rb; cnd = c; valE = e; valM = m; commit = cm;
  endtask

  // One clock edge; the model commits E then M so M wins on a clash.
  task automatic step();
    logic [3:0] sa, sb, de, dm;
    @(posedge clk);
    if (rst_n && commit) begin
      ref_ids(icode, rA, rB, cnd, sa, sb, de, dm);
      if (de != 4'hF) model[de] = valE;
      if (dm != 4'hF) model[dm] = valM;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 15; i++) model[i] = '0;
    rst_n = 1'b0;
    drive(4'h1, 4'hF, 4'hF, 1'b0, '0, '0, 1'b0);

    // Reset state: registers read 0 without any clock edge.
    #2;
    drive(4'h6, 4'h3, 4'h9, 1'b0, '0, '0, 1'b0);
    #1;
    expect_eq("reset_valA", valA, '0);
    expect_eq("reset_valB", valB, '0);
    #9 rst_n = 1'b1;
    step();

    // Fill every register so the following reset has something to clear.
    for (int i = 0; i < 15; i++) begin
      drive(4'h3, 4'hF, 4'(i), 1'b0, {$urandom, $urandom}, '0, 1'b1);
      step();
    end
    drive(4'h6, 4'h7, 4'hB, 1'b0, '0, '0, 1'b0);
    #1;
    check_all("filled");

    // Mid-cycle reset with a write pending: discarded, all registers zero.
    drive(4'h3, 4'hF, 4'h5, 1'b0, 64'hBAD0_BAD0, '0, 1'b1);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 15; i++) model[i] = '0;
    @(posedge clk);
    #2;
    commit = 1'b0;
    rst_n  = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(4'h2, 4'(i), 4'hF, 1'b0, '0, '0, 1'b0);
      #1;
      expect_eq($sformatf("reset_reg%0d", i), valA, '0);
    end
    step();

    // irmovq then read back through OPq; no bypass before the edge.
    drive(4'h6, 4'h2, 4'h2, 1'b0, '0, '0, 1'b0);
    #1;
    expect_eq("irmovq_pre_valB", valB, '0);
    drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, '0, 1'b1);
    step();
    drive(4'h6, 4'h2, 4'h2, 1'b0, '0, '0, 1'b0);
    #1;
    expect_eq("irmovq_valA", valA, 64'h1234);
    expect_eq("irmovq_valB", valB, 64'h1234);

    // cmovXX with cnd = 0 then cnd = 1.
    drive(4'h2, 4'h1, 4'h3, 1'b0, 64'd7, '0, 1'b1);
    #1;
    expect_eq("cmov_nc_dstE", {60'd0, dstE}, 64'hF);
    step();
    drive(4'h6, 4'h3, 4'h3, 1'b0, '0, '0, 1'b0);
    #1;
    expect_eq("cmov_nc_reg3", valA, '0);
    drive(4'h2, 4'h1, 4'h3, 1'b1, 64'd7, '0, 1'b1);
    #1;
    expect_eq("cmov_c_dstE", {60'd0, dstE}, 64'h3);
    step();
    drive(4'h6, 4'h3, 4'h3, 1'b0, '0, '0, 1'b0);
    #1;
    expect_eq("cmov_c_reg3", valA, 64'd7);

    // popq %rsp: both ports hit reg4, M wins.
    drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'h55, 1'b1);
    #1;
    expect_eq("popq_dstE", {60'd0, dstE}, 64'h4);
    expect_eq("popq_dstM", {60'd0, dstM}, 64'h4);
    step();
    drive(4'h6, 4'h4, 4'hF, 1'b0, '0, '0, 1'b0);
    #1;
    expect_eq("popq_reg4", valA, 64'h55);

    // pushq / ret / call decode.
    drive(4'hA, 4'h0, 4'hF, 1'b0, '0, '0, 1'b0);
    #1;
    expect_eq("pushq_srcA", {60'd0, srcA}, 64'h0);
    expect_eq("pushq_srcB", {60'd0, srcB}, 64'h4);
    expect_eq("pushq_dstE", {60'd0, dstE}, 64'h4);
    expect_eq("pushq_dstM", {60'd0, dstM}, 64'hF);
    drive(4'h9, 4'hF, 4'hF, 1'b0, '0, '0, 1'b0);
    #1;
    expect_eq("ret_srcA", {60'd0, srcA}, 64'h4);
    expect_eq("ret_srcB", {60'd0, srcB}, 64'h4);
    drive(4'h8, 4'hF, 4'hF, 1'b0, '0, '0, 1'b0);
    #1;
    expect_eq("call_srcA", {60'd0, srcA}, 64'hF);

    // commit = 0 suppresses the mrmovq load, commit = 1 performs it.
    drive(4'h5, 4'h6, 4'h1, 1'b0, '0, 64'hDEAD, 1'b0);
    step();
    drive(4'h6, 4'h6, 4'hF, 1'b0, '0, '0, 1'b0);
    #1;
    expect_eq("nocommit_reg6", valA, '0);
    drive(4'h5, 4'h6, 4'h1, 1'b0, '0, 64'hDEAD, 1'b1);
    step();
    drive(4'h6, 4'h6, 4'hF, 1'b0, '0, '0, 1'b0);
    #1;
    expect_eq("commit_reg6", valA, 64'hDEAD);

    // Random instruction stream, including undefined icodes and ID 0xF.
    for (int n = 0; n < 300; n++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom_range(0, 3) != 0));
      #1;
      check_all($sformatf("rand%0d", n));
      step();
    end

    // Sweep every register against the model once more.
    for (int i = 0; i < 15; i++) begin
      drive(4'h6, 4'(i), 4'(14 - i), 1'b0, '0, '0, 1'b0);
      #1;
      check_all($sformatf("final%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
